// File: rtl/cci_mpf_rd_req_arb.sv
// Round-robin arbiter sharing one MPF read-request channel among N_REQ
// requesters. Tracks in-flight reads per requester, steers responses back
// by tag and provides a drain/quiesce controller.
//
// Handshake: requester i's address is consumed in any cycle where
// req_valid[i] && req_ready[i]. req_ready is a combinational one-hot grant
// (or zero). The accepted request appears on out_valid/out_addr/out_tag one
// cycle later; the channel never back-pressures except through
// out_almost_full, which suppresses new grants in the same cycle.
module cci_mpf_rd_req_arb #(
  parameter int N_REQ           = 4,
  parameter int ADDR_W          = 42,
  parameter int MAX_OUTSTANDING = 64,
  localparam int TAG_W          = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [TAG_W-1:0]        out_tag,
  input  logic                    out_almost_full,
  input  logic                    rsp_valid,
  input  logic [TAG_W-1:0]        rsp_tag,
  output logic [N_REQ-1:0]        rsp_route,
  input  logic                    drain_req,
  output logic                    drained,
  output logic                    not_empty,
  output logic                    err_underflow,
  output logic [1:0]              dbg_state
);

  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int TAG_SPAN = 1 << TAG_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [TAG_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]    cnt_q [N_REQ];
  logic [CNT_W-1:0]    cnt_d [N_REQ];

  logic                run_ok;
  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    grant;
  logic                grant_any;
  logic [TAG_W-1:0]    grant_idx;
  logic [TAG_W-1:0]    scan_idx;
  logic [ADDR_W-1:0]   sel_addr;

  logic [TAG_SPAN-1:0] tag_dec;
  logic [N_REQ-1:0]    rsp_hit;
  logic                tag_bad;
  logic                underflow;
  logic                all_idle;
  logic                any_cnt_next;

  assign dbg_state = state_q;
  assign req_ready = grant;

  // Eligibility: a requester may be granted only while running, not draining,
  // with channel space and below its in-flight limit.
  always_comb begin
    run_ok = (state_q == ST_RUN) && !drain_req && !out_almost_full;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] < CNT_MAX) && run_ok;
    end
  end

  // Round-robin scan starting at rr_ptr; first eligible requester wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = TAG_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_any && eligible[scan_idx]) begin
        grant_any       = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  // Address mux for the granted requester.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Response tag decode; tags beyond N_REQ-1 are flagged rather than routed.
  always_comb begin
    tag_dec = TAG_SPAN'(1) << rsp_tag;
    rsp_hit = rsp_valid ? tag_dec[N_REQ-1:0] : '0;
    tag_bad = rsp_valid && !(|tag_dec[N_REQ-1:0]);
  end

  // Per-requester in-flight counters; a response on an empty counter is an
  // underflow and never wraps the count.
  always_comb begin
    underflow    = tag_bad;
    all_idle     = 1'b1;
    any_cnt_next = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) all_idle = 1'b0;
      if (rsp_hit[i] && (cnt_q[i] == '0)) underflow = 1'b1;
      case ({grant[i], rsp_hit[i] && (cnt_q[i] != '0)})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      if (cnt_d[i] != '0) any_cnt_next = 1'b1;
    end
  end

  // Quiesce controller next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req)                 state_d = ST_RUN;
        else if (all_idle && !out_valid) state_d = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      rr_ptr        <= '0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_tag       <= '0;
      rsp_route     <= '0;
      drained       <= 1'b0;
      not_empty     <= 1'b0;
      err_underflow <= 1'b0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= grant_any;
      rsp_route <= rsp_hit;
      drained   <= (state_d == ST_DRAINED);
      not_empty <= any_cnt_next || grant_any;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
      if (underflow) err_underflow <= 1'b1;
      if (grant_any) begin
        out_addr <= sel_addr;
        out_tag  <= grant_idx;
        rr_ptr   <= (grant_idx == LAST_IDX) ? '0 : grant_idx + TAG_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_rd_req_arb.sv
// Bench for cci_mpf_rd_req_arb: directed stimulus, a cycle-level behavioural
// model with an expected-request queue, and literal spot checks.
module tb_cci_mpf_rd_req_arb;

  localparam int N   = 4;
  localparam int AW  = 42;
  localparam int MAX = 64;
  localparam int TW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [AW-1:0]   out_addr;
  logic [TW-1:0]   out_tag;
  logic            out_almost_full;
  logic            rsp_valid;
  logic [TW-1:0]   rsp_tag;
  logic [N-1:0]    rsp_route;
  logic            drain_req;
  logic            drained;
  logic            not_empty;
  logic            err_underflow;
  logic [1:0]      dbg_state;

  cci_mpf_rd_req_arb #(.N_REQ(N), .ADDR_W(AW), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_tag(out_tag),
    .out_almost_full(out_almost_full),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_route(rsp_route),
    .drain_req(drain_req), .drained(drained), .not_empty(not_empty),
    .err_underflow(err_underflow), .dbg_state(dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [TW+AW-1:0] exp_q[$];
  int       m_cnt [N];
  int       m_rr;
  int       m_st;            // 0 running, 1 draining, 2 drained
  int       nxt_st;
  int       g;
  int       idx;
  bit       all_zero;
  bit       exp_ov;
  bit       exp_ne;
  bit       exp_dr;
  bit       exp_err;
  logic [N-1:0] exp_route;
  logic [N-1:0] exp_ready;
  logic [TW+AW-1:0] item;
  int       obs_n;
  int       obs_tag [16];

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_rr = 0; m_st = 0;
      exp_ov = 0; exp_ne = 0; exp_dr = 0; exp_err = 0; exp_route = '0;
      exp_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_addr", out_addr, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_rsp_route", rsp_route, 0);
      check("rst_drained", drained, 0);
      check("rst_not_empty", not_empty, 0);
      check("rst_err", err_underflow, 0);
    end else begin
      // registered outputs vs model
      check("out_valid", out_valid, exp_ov);
      if (out_valid) begin
        if (obs_n < 16) obs_tag[obs_n] = int'(out_tag);
        obs_n++;
        if (exp_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          item = exp_q.pop_front();
          check("out_tag_addr", {out_tag, out_addr}, item);
        end
      end
      check("rsp_route", rsp_route, exp_route);
      check("not_empty", not_empty, exp_ne);
      check("drained", drained, exp_dr);
      check("err_underflow", err_underflow, exp_err);

      // expected grant this cycle
      g = -1;
      if (m_st == 0 && !drain_req && !out_almost_full) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (g < 0 && req_valid[idx] && m_cnt[idx] < MAX) g = idx;
        end
      end
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      check("req_ready", req_ready, exp_ready);

      // advance the model across the coming edge
      all_zero = 1;
      for (int i = 0; i < N; i++) if (m_cnt[i] != 0) all_zero = 0;
      case (m_st)
        0: nxt_st = drain_req ? 1 : 0;
        1: nxt_st = !drain_req ? 0 : ((all_zero && !exp_ov) ? 2 : 1);
        default: nxt_st = drain_req ? 2 : 0;
      endcase
      exp_route = '0;
      if (rsp_valid) begin
        if (int'(rsp_tag) < N) begin
          exp_route[rsp_tag] = 1'b1;
          if (m_cnt[rsp_tag] > 0) m_cnt[rsp_tag]--;
          else exp_err = 1;
        end else begin
          exp_err = 1;
        end
      end
      if (g >= 0) begin
        m_cnt[g]++;
        m_rr = (g + 1) % N;
        exp_q.push_back({TW'(g), req_addr[g*AW +: AW]});
      end
      exp_ov = (g >= 0);
      m_st   = nxt_st;
      exp_dr = (nxt_st == 2);
      exp_ne = exp_ov;
      for (int i = 0; i < N; i++) if (m_cnt[i] != 0) exp_ne = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'({$urandom, $urandom_range(0, 32'hffff_ffff)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    req_valid = '0; req_addr = '0; out_almost_full = 1'b0;
    rsp_valid = 1'b0; rsp_tag = '0; drain_req = 1'b0;
    obs_n = 0;
    repeat (3) next_cycle();
    reset = 1'b0;
    #3;
    check("init_not_empty", not_empty, 0);
    check("init_drained", drained, 0);

    // Saturate all four requesters: round-robin order, 64 per requester.
    obs_n = 0;
    req_valid = '1;
    repeat (260) next_cycle();
    #3;
    check("t1_ready_stopped", req_ready, 0);
    check("t1_total_grants", obs_n, 256);
    for (int k = 0; k < 8; k++) check("t1_tag_order", obs_tag[k], k % 4);
    check("t1_not_empty", not_empty, 1);
    req_valid = '0;
    do_reset();

    // Lone requester 2, then again with the pointer at 3 (scan wraps).
    req_valid = 4'b0100;
    #3 check("t2_first", req_ready, 4'b0100);
    next_cycle(); req_valid = '0;
    next_cycle(); req_valid = 4'b0100;
    #3 check("t2_wrap", req_ready, 4'b0100);
    next_cycle(); req_valid = '1;
    #3 check("t2_ptr_after", req_ready, 4'b1000);
    next_cycle(); req_valid = '0;

    // Almost-full holds off all grants; pointer is unchanged afterwards.
    req_valid = '1; out_almost_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #3 check("t3_blocked", req_ready, 0);
      next_cycle();
    end
    out_almost_full = 1'b0;
    #3 check("t3_resume", req_ready, 4'b0001);
    next_cycle(); req_valid = '0;

    // Build cnt[1]=5, then grant and respond to 1 in the same cycle.
    req_valid = 4'b0010;
    repeat (5) next_cycle();
    rsp_valid = 1'b1; rsp_tag = 2'd1;
    #3 check("t4_grant", req_ready, 4'b0010);
    next_cycle(); req_valid = '0; rsp_valid = 1'b0;
    #3 check("t4_route", rsp_route, 4'b0010);
    check("t4_out_tag", out_tag, 1);
    for (int k = 0; k < 5; k++) begin
      next_cycle(); rsp_valid = 1'b1; rsp_tag = 2'd1;
    end
    next_cycle(); rsp_valid = 1'b0;
    #3 check("t4_count_five", err_underflow, 0);
    do_reset();

    // Ten reads outstanding, drain, then release.
    req_valid = '1;
    repeat (10) next_cycle();
    drain_req = 1'b1;
    #3 check("t5_blocked", req_ready, 0);
    for (int j = 0; j < 10; j++) begin
      next_cycle(); rsp_valid = 1'b1; rsp_tag = TW'(j % 4);
    end
    next_cycle(); rsp_valid = 1'b0;
    #3 check("t5_not_yet", drained, 0);
    check("t5_idle", not_empty, 0);
    next_cycle();
    #3 check("t5_drained", drained, 1);
    next_cycle(); drain_req = 1'b0;
    #3 check("t5_hold", req_ready, 0);
    next_cycle();
    #3 check("t5_released", drained, 0);
    check("t5_regrant", req_ready, 4'b0100);
    check("t5_err", err_underflow, 0);
    next_cycle(); req_valid = '0;
    do_reset();

    // Underflow on an empty tag is sticky until reset.
    rsp_valid = 1'b1; rsp_tag = 2'd0;
    next_cycle(); rsp_valid = 1'b0;
    #3 check("t6_err_set", err_underflow, 1);
    check("t6_route", rsp_route, 4'b0001);
    repeat (5) next_cycle();
    #3 check("t6_err_sticky", err_underflow, 1);
    // A read in flight across reset comes back as an underflow.
    req_valid = 4'b0001;
    next_cycle(); req_valid = '0;
    next_cycle();
    do_reset();
    #3 check("t6_err_cleared", err_underflow, 0);
    next_cycle(); rsp_valid = 1'b1; rsp_tag = 2'd0;
    next_cycle(); rsp_valid = 1'b0;
    #3 check("t6_stale_rsp", err_underflow, 1);
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cci_mpf_rd_req_arb.md
Name: cci_mpf_rd_req_arb

Overview:
- Shares one MPF read-request channel (c0Tx-style, toward the FIU side of the pipeline) among N_REQ independent requesters using round-robin arbitration.
- Limits outstanding reads per requester and routes read responses back to the issuing requester by tag.
- Provides a drain/quiesce controller so software or a VC-mapping change can stop new reads and wait for all in-flight reads to complete.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- ADDR_W, 42: line address width.
- MAX_OUTSTANDING, 64: maximum in-flight reads per requester, 1..255.
- TAG_W, $clog2(N_REQ) (derived, localparam): response tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_addr  in  N_REQ*ADDR_W  per-requester line address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  out  N_REQ  per-requester grant; the request is consumed in any cycle where req_valid[i] && req_ready[i].
- out_valid  out  1  registered read request to the channel.
- out_addr  out  ADDR_W  registered address.
- out_tag  out  TAG_W  requester index, carried in Mdata.
- out_almost_full  in  1  channel almost-full; the channel tolerates at least 2 further requests after assertion.
- rsp_valid  in  1  read response (EOP) from the channel.
- rsp_tag  in  TAG_W  Mdata tag of the response.
- rsp_route  out  N_REQ  registered one-hot response steering.
- drain_req  in  1  level; request quiesce.
- drained  out  1  quiesce complete.
- not_empty  out  1  any read in flight.
- err_underflow  out  1  sticky; response arrived for a tag with count 0.

Behaviour:
- Reset (asynchronous assertion): out_valid=0, out_addr=0, out_tag=0, rsp_route=0, drained=0, not_empty=0, err_underflow=0, all counts=0, rr_ptr=0, state=RUN.
- Eligibility:
  - eligible[i] = req_valid[i] && cnt[i] < MAX_OUTSTANDING && !out_almost_full && state==RUN.
- Arbitration (combinational, single grant per cycle):
  - Scan from rr_ptr upward modulo N_REQ; grant the first eligible requester.
  - req_ready is one-hot or zero and never asserts for an ineligible requester.
  - On a grant to i, rr_ptr <= (i+1) mod N_REQ. Wrap from N_REQ-1 goes to 0. With no grant, rr_ptr holds.
- Output latency: 1 cycle. The cycle after a grant, out_valid=1 with the granted address and tag. Otherwise out_valid=0. No output stall exists; almost-full gating is the only flow control.
- Counters:
  - cnt[i] width $clog2(MAX_OUTSTANDING+1).
  - Increments on grant to i; decrements on rsp_valid with rsp_tag==i.
  - Simultaneous increment and decrement for the same i leaves cnt[i] unchanged.
  - A response to a tag with cnt==0 does not decrement (no wrap) and sets err_underflow, which clears only on reset.
  - A response with rsp_tag >= N_REQ is ignored and sets err_underflow.
- rsp_route: registered; one cycle after rsp_valid, bit rsp_tag=1 for one cycle.
- not_empty: registered; equals OR of (cnt != 0) OR out_valid, evaluated with next-state values.
- Quiesce FSM:
  - RUN -> DRAIN when drain_req=1; no grants from the same cycle onward.
  - DRAIN -> DRAINED when all cnt==0 and out_valid==0 (in that cycle), with drain_req still 1. drained=1 from the cycle after entry.
  - DRAIN or DRAINED -> RUN when drain_req=0; drained clears in that same transition edge, and grants resume the cycle after.
  - Responses continue to be counted and routed in every state.
- Reset mid-operation: all state clears immediately. In-flight responses that arrive after reset deasserts hit cnt==0 and flag err_underflow; this is the required behaviour.

Test Plan:
1. Reset, then all 4 requesters valid continuously with no responses and MAX_OUTSTANDING=64 → grants in order 0,1,2,3,0,...; out_tag sequence matches, 1 cycle after each req_ready; each counter stops at 64, with 256 total grants, then all req_ready=0.
2. Only requester 2 valid with rr_ptr=3 → scan wraps 3→0→1→2; grant to 2 in the first cycle; next rr_ptr=3.
3. out_almost_full=1 for 5 cycles with all valid → zero grants during those cycles; arbitration resumes from the unchanged rr_ptr the cycle after deassertion.
4. cnt[1]=5, then grant to 1 and rsp_tag=1 in the same cycle → cnt[1] stays 5; rsp_route=4'b0010 the next cycle.
5. 10 reads outstanding and drain_req=1 → no further grants; drained rises exactly 1 cycle after the 10th response; drain_req=0 → drained=0 and a grant occurs the following cycle.
6. rsp_valid with tag 0 while cnt[0]=0 → cnt[0] stays 0, err_underflow=1 and remains set until reset.
